btn_debounce: RTL and testbench

- Input conditioner for board buttons and switches.
- Sits directly upstream of the computer's PORTI/PORTJ inputs and the reset logic, replacing ad-hoc 100 Hz sampling.
- Synchronises asynchronous pad inputs, debounces each bit with a per-bit stability counter, and produces clean levels, one-cycle rise/fall strobes and sticky press flags for software polling.

---
 rtl/btn_debounce_if.sv | 27 ++
 rtl/btn_debounce.sv | 84 ++++++++
 tb/tb_btn_debounce.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce_if : pad inputs and conditioned outputs of btn_debounce |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface btn_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic             tick;

  modport master (
    output din, evt_clr,
    input  dout, rise, fall, evt, tick
  );

  modport slave (
    input  din, evt_clr,
    output dout, rise, fall, evt, tick
  );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : 2-flop sync, tick-sampled per-bit debounce, strobes  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module btn_debounce #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1000,
  parameter int STABLE   = 4
) (
  input wire logic      clk,
  input wire logic      reset,
  btn_debounce_if.slave bus
);
  localparam int              PW       = $clog2(PRESCALE);
  localparam int              CW       = $clog2(STABLE);
  localparam logic [PW-1:0]   PC_LAST  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [PW-1:0]    pc_q, pc_d;
  logic             tick;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] evt_q,  evt_d;

  assign tick = (pc_q == PC_LAST);
  assign pc_d = tick ? '0 : pc_q + PW'(1);

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    // Registered rise feeds the flag, so a set always beats a coincident clear.
    evt_d  = rise_q | (evt_q & ~bus.evt_clr);
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] == dout_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]  = '0;
          dout_d[i] = ~dout_q[i];
          rise_d[i] = ~dout_q[i];
          fall_d[i] = dout_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      pc_q   <= '0;
      cnt_q  <= '{default: '0};
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
    end else begin
      s1_q   <= bus.din;
      s2_q   <= s1_q;
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.evt  = evt_q;
  assign bus.tick = tick;
endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_btn_debounce : directed scenarios plus random pad activity       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_btn_debounce;
  localparam int W = 4;
  localparam int P = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btn_debounce_if #(.WIDTH(W)) bus ();

  btn_debounce #(.WIDTH(W), .PRESCALE(P), .STABLE(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference: accepted level flips once the last S tick samples all disagree with it.
  logic [W-1:0] m_dout, m_rise, m_fall, m_evt;
  logic [W-1:0] m_dly1, m_dly2;
  int           m_phase;
  logic [W-1:0] samp[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic [W-1:0] din_v, input logic [W-1:0] clr_v);
    logic [W-1:0] nd;
    bit all_diff;
    if (rst_v) begin
      m_dout = '0; m_rise = '0; m_fall = '0; m_evt = '0;
      m_dly1 = '0; m_dly2 = '0; m_phase = 0;
      samp.delete();
      return;
    end
    m_evt  = m_rise | (m_evt & ~clr_v);
    m_rise = '0;
    m_fall = '0;
    if (m_phase == P - 1) begin
      samp.push_back(m_dly2);
      if (samp.size() > S) void'(samp.pop_front());
      nd = m_dout;
      if (samp.size() == S) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (samp[j]) if (samp[j][i] == m_dout[i]) all_diff = 1'b0;
          if (all_diff) begin
            nd[i]     = ~m_dout[i];
            m_rise[i] = nd[i];
            m_fall[i] = ~nd[i];
          end
        end
      end
      m_dout = nd;
    end
    m_dly2  = m_dly1;
    m_dly1  = din_v;
    m_phase = (m_phase + 1) % P;
  endtask

  task automatic step();
    logic         rv;
    logic [W-1:0] dv, cv;
    rv = reset;
    dv = bus.din;
    cv = bus.evt_clr;
    @(posedge clk);
    model_edge(rv, dv, cv);
    #1;
    cyc++;
    check_eq("dout", 32'(bus.dout), 32'(m_dout));
    check_eq("rise", 32'(bus.rise), 32'(m_rise));
    check_eq("fall", 32'(bus.fall), 32'(m_fall));
    check_eq("evt",  32'(bus.evt),  32'(m_evt));
    check_eq("tick", 32'(bus.tick), 32'(m_phase == P - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nrise, nfall, rise_cyc, bounce_end;
    bit found;
    logic [W-1:0] clr;

    reset = 1'b1;
    bus.din = '0;
    bus.evt_clr = '0;
    step();
    step();
    check_eq("reset_outputs", 32'({bus.dout, bus.rise, bus.fall, bus.evt, bus.tick}), 32'd0);
    reset = 1'b0;

    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 3 || k == 7 || k == 11) check_eq("tick_period", 32'(bus.tick), 32'd1);
      if (k == 4) check_eq("tick_gap", 32'(bus.tick), 32'd0);
    end

    // Clean press on bit 0
    bus.din[0] = 1'b1;
    lat = -1; nrise = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (bus.rise[0]) nrise++;
      if (lat < 0 && bus.dout[0]) begin
        lat = k;
        check_eq("step_rise_with_dout", 32'(bus.rise[0]), 32'd1);
      end
    end
    check_eq("step_latency_window", 32'(lat >= 11 && lat <= 14), 32'd1);
    check_eq("step_rise_count", 32'(nrise), 32'd1);
    check_eq("step_evt_sticky", 32'(bus.evt[0]), 32'd1);

    // Short glitch on bit 1
    nrise = 0;
    bus.din[1] = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 6) bus.din[1] = 1'b0;
      step();
      if (bus.rise[1] || bus.dout[1] || bus.evt[1]) nrise++;
    end
    check_eq("glitch_suppressed", 32'(nrise), 32'd0);

    // Bounce on bit 2, then settle high
    nrise = 0; nfall = 0; rise_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) bus.din[2] = ~bus.din[2];
      step();
      if (bus.rise[2]) begin nrise++; rise_cyc = cyc; end
      if (bus.fall[2]) nfall++;
    end
    bounce_end = cyc;
    bus.din[2] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.rise[2]) begin nrise++; rise_cyc = cyc; end
      if (bus.fall[2]) nfall++;
    end
    check_eq("bounce_rise_count", 32'(nrise), 32'd1);
    check_eq("bounce_fall_count", 32'(nfall), 32'd0);
    check_eq("bounce_rise_late", 32'(rise_cyc > bounce_end), 32'd1);
    check_eq("bounce_dout", 32'(bus.dout[2]), 32'd1);

    // Release bit 0, clear its flag, then set-vs-clear race on bit 3
    bus.din[0] = 1'b0;
    nfall = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.fall[0]) nfall++;
    end
    check_eq("release_fall_count", 32'(nfall), 32'd1);
    check_eq("release_dout", 32'(bus.dout[0]), 32'd0);
    bus.evt_clr = 4'b0001;
    step();
    bus.evt_clr = '0;
    check_eq("clear_evt0", 32'(bus.evt[0]), 32'd0);
    bus.din[3] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (bus.rise[3]) found = 1'b1;
    end
    check_eq("rise3_seen", 32'(found), 32'd1);
    bus.evt_clr = 4'b1000;
    step();
    bus.evt_clr = '0;
    check_eq("set_beats_clear", 32'(bus.evt[3]), 32'd1);
    step();
    check_eq("set_beats_clear_hold", 32'(bus.evt[3]), 32'd1);

    // Reset in the middle of a debounce
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.din = 4'b1111;
    for (int k = 0; k < 8; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midreset_outputs", 32'({bus.dout, bus.rise, bus.fall, bus.evt}), 32'd0);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      step();
      if (bus.dout != '0) begin
        lat = k;
        check_eq("midreset_dout_all", 32'(bus.dout), 32'hF);
        check_eq("midreset_rise_all", 32'(bus.rise), 32'hF);
      end
    end
    check_eq("midreset_latency_window", 32'(lat >= 11 && lat <= 14), 32'd1);

    // Random pad activity, two toggle densities, sparse clears and resets
    for (int k = 0; k < 900; k++) begin
      reset = ($urandom_range(0, 249) == 0);
      for (int b = 0; b < W; b++) begin
        if (k < 450) begin
          if ($urandom_range(0, 7) == 0) bus.din[b] = ~bus.din[b];
        end else begin
          if ($urandom_range(0, 29) == 0) bus.din[b] = ~bus.din[b];
        end
        clr[b] = ($urandom_range(0, 7) == 0);
      end
      bus.evt_clr = clr;
      step();
    end
    reset = 1'b0;
    bus.evt_clr = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
